// File: rtl/sop_vector_driver.sv
// Purpose : exhaustive 32-vector sweep of a 5-input SOP function; checks S_OR3 against EXP_MASK.
// Latency : each vector is held SETTLE+1 cycles; a full sweep keeps busy high 32*(SETTLE+1) cycles.
// Backpr. : none; start is ignored while busy, abort ends a running sweep and invalidates results.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          sweep control pulses
//   S_OR3                 response of the function under test (sampled only in SAMPLE)
//   X,Y,Z,K,M             registered stimulus = current vector index (X is the MSB), 0 when idle
//   busy, done, pass      sweep status; pass is meaningful only while done is high
//   err_cnt               mismatching vectors in the last sweep (0..32)
//   first_err_idx/_valid  index of the first mismatch and whether one was seen
//   captured              raw sampled responses, bit i = vector i
module sop_vector_driver #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [31:0] EXP_MASK = 32'h0AAE8D5D
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        S_OR3,
   output logic        X,
   output logic        Y,
   output logic        Z,
   output logic        K,
   output logic        M,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [5:0]  err_cnt,
   output logic [4:0]  first_err_idx,
   output logic        first_err_valid,
   output logic [31:0] captured
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Last value of the settle counter before sampling. With SETTLE = 0 the HOLD
   // state is skipped entirely so that every vector still takes exactly one cycle.
   localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
   localparam state_t     VEC_ENTRY   = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;
   localparam logic [5:0] ERR_MAX     = 6'd32;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [5:0]  err_q, err_d;
   logic [4:0]  fidx_q, fidx_d;
   logic        fvld_q, fvld_d;
   logic [31:0] cap_q, cap_d;

   logic        mismatch;
   logic [5:0]  err_nxt;

   // ------------------------------------------------------------------
   // Next-state and result logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fidx_d   = fidx_q;
      fvld_d   = fvld_q;
      cap_d    = cap_q;
      mismatch = 1'b0;
      err_nxt  = err_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // abort has no meaning outside a sweep, so start always wins here.
            if (start) begin
               state_d = VEC_ENTRY;
               idx_d   = 5'd0;
               cnt_d   = 4'd0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = 6'd0;
               fidx_d  = 5'd0;
               fvld_d  = 1'b0;
               cap_d   = 32'd0;
            end
         end

         ST_HOLD: begin
            if (abort) begin
               state_d = ST_IDLE;
               idx_d   = 5'd0;
               cnt_d   = 4'd0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end

         ST_SAMPLE: begin
            if (abort) begin
               // Partial err_cnt/captured stay visible but done/pass say they are invalid.
               state_d = ST_IDLE;
               idx_d   = 5'd0;
               cnt_d   = 4'd0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               cap_d[idx_q] = S_OR3;
               mismatch     = (S_OR3 != EXP_MASK[idx_q]);
               if (mismatch && (err_q != ERR_MAX)) begin
                  err_nxt = err_q + 6'd1;
               end
               err_d = err_nxt;
               if (mismatch && !fvld_q) begin
                  fvld_d = 1'b1;
                  fidx_d = idx_q;
               end
               // Exit on the last vector before incrementing so the index never wraps.
               if (idx_q == 5'd31) begin
                  state_d = ST_DONE;
                  idx_d   = 5'd0;
                  done_d  = 1'b1;
                  pass_d  = (err_nxt == 6'd0);
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = VEC_ENTRY;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = 5'd0;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 5'd0;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 6'd0;
         fidx_q  <= 5'd0;
         fvld_q  <= 1'b0;
         cap_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fidx_q  <= fidx_d;
         fvld_q  <= fvld_d;
         cap_q   <= cap_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all come straight from flops (busy is a decode of state_q).
   // idx_q is forced to 0 outside a sweep, so the stimulus rests at 0.
   // ------------------------------------------------------------------
   assign X               = idx_q[4];
   assign Y               = idx_q[3];
   assign Z               = idx_q[2];
   assign K               = idx_q[1];
   assign M               = idx_q[0];
   assign busy            = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_cnt         = err_q;
   assign first_err_idx   = fidx_q;
   assign first_err_valid = fvld_q;
   assign captured        = cap_q;

endmodule

// File: doc/sop_vector_driver.md
Name: sop_vector_driver

Overview:
Exhaustive stimulus generator and response checker for the 5-input SOP blocks (X, Y, Z, K, M → S_OR3). It drives all 32 input combinations in ascending order into the function under test and samples its output. It compares each sample against an expected truth-table mask and reports pass/fail, error count and first failing vector. It sits on the opposite side of the function interface: it drives its inputs and reads its output.

Parameters:
SETTLE, 1, extra cycles each vector is held before its output is sampled (0..15)
EXP_MASK, 32'h0AAE8D5D, expected output; bit i = expected S_OR3 for vector index i

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a sweep when idle
abort  input  1  ends a running sweep; results are invalidated
S_OR3  input  1  output of the function under test
X  output  1  stimulus, index bit 4 (MSB)
Y  output  1  stimulus, index bit 3
Z  output  1  stimulus, index bit 2
K  output  1  stimulus, index bit 1
M  output  1  stimulus, index bit 0 (LSB)
busy  output  1  sweep in progress
done  output  1  sweep completed; held until next accepted start
pass  output  1  valid when done; 1 when err_cnt == 0
err_cnt  output  6  number of mismatching vectors (0..32)
first_err_idx  output  5  index of the first mismatch
first_err_valid  output  1  at least one mismatch recorded
captured  output  32  sampled S_OR3; bit i holds the sample for vector i

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State IDLE; all outputs 0; index counter 0; settle counter 0.
- Stimulus outputs:
  - X..M are registered and equal the current index {X,Y,Z,K,M}.
  - In IDLE, DONE and ABORTED they are held at 0.
- FSM states: IDLE, HOLD, SAMPLE, DONE.
- IDLE:
  - start = 1 → HOLD with index 0.
  - Clear err_cnt, first_err_valid, first_err_idx, captured and done.
  - busy = 1 from the next cycle.
- HOLD:
  - Vector held while the settle counter counts SETTLE cycles.
  - SETTLE = 0 → go straight to SAMPLE on the next edge.
- SAMPLE (one cycle; vector still driven):
  - captured[index] <= S_OR3.
  - If S_OR3 != EXP_MASK[index]: increment err_cnt.
  - On the first such mismatch: set first_err_valid = 1 and first_err_idx = index.
  - index == 31 → DONE. Otherwise index + 1 and → HOLD.
- Timing: each vector occupies exactly SETTLE + 1 cycles, so busy is high for 32 × (SETTLE + 1) cycles (default 64).
- DONE:
  - busy = 0, done = 1, pass = (err_cnt == 0).
  - Results hold until start = 1, which clears them and restarts a sweep (same as from IDLE).
- start while busy: ignored, no restart.
- abort while busy:
  - Next state IDLE; busy = 0; done = 0; pass = 0.
  - err_cnt and captured keep their partial values and are considered invalid.
- abort and start in the same cycle:
  - abort wins while busy.
  - In IDLE/DONE, start wins and abort is ignored.
- Index wrap: the counter never wraps within a sweep. The exit happens at index 31, before any increment.
- err_cnt saturates at 32; this is reachable only with a fully inverted response.
- Reset mid-sweep: immediate return to the reset values; no partial results are retained.
- S_OR3 is sampled only in SAMPLE. It must be stable within SETTLE + 1 cycles of a stimulus change, which the caller ensures via SETTLE.
- No combinational path from any input to any output.

Test Plan:
- Loopback to a correct SOP model, SETTLE = 1, start pulse → busy for 64 cycles, then done = 1, pass = 1, err_cnt = 0, first_err_valid = 0, captured = 32'h0AAE8D5D.
- S_OR3 tied to 0 → done, pass = 0, err_cnt = 16, first_err_idx = 0, captured = 0. Tied to 1 → err_cnt = 16, first_err_idx = 1, captured = 32'hFFFFFFFF.
- SETTLE = 0, correct model → busy exactly 32 cycles; X..M step 0,1,2,…,31 on consecutive cycles; pass = 1.
- Model with vector 19 forced to 0 → err_cnt = 1, first_err_idx = 19, captured = 32'h0AA68D5D. A second start pulse during the sweep is ignored (busy stays high, total duration unchanged).
- abort at index 10 → busy = 0 next cycle, done = 0, stimulus = 0. A following start runs a full clean sweep with pass = 1.
- rst_n low for 1 cycle at index 20 → all outputs 0 immediately (asynchronously). A start after release produces a correct full sweep.
